// File: rtl/regfile_dump_sequencer.sv
// Debug readout: walks CPU registers FIRST_REG..LAST_REG through regNo/val and
// streams each captured value on a valid/ready port, accumulating a wrapping checksum.
module regfile_dump_sequencer #(
  parameter int FIRST_REG     = 0,
  parameter int LAST_REG      = 31,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        startin,
  input  logic        start,
  output logic [4:0]  regNo,
  input  logic [31:0] val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [4:0]    FIRST    = 5'(FIRST_REG);
  localparam logic [4:0]    LAST     = 5'(LAST_REG);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HOLD, DONE} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  index;
    logic        last;
  } elem_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0]    reg_nxt;
  elem_t         elem, elem_nxt;
  logic          vld_nxt, busy_nxt, done_nxt;
  logic [31:0]   sum_nxt;
  logic          xfer;

  assign xfer      = out_valid & out_ready;
  assign out_data  = elem.data;
  assign out_index = elem.index;
  assign out_last  = elem.last;

  always_ff @(posedge clk) begin
    if (startin) begin
      state     <= IDLE;
      cnt       <= '0;
      regNo     <= FIRST;
      elem      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      regNo     <= reg_nxt;
      elem      <= elem_nxt;
      out_valid <= vld_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      checksum  <= sum_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    reg_nxt   = regNo;
    elem_nxt  = elem;
    vld_nxt   = out_valid;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    sum_nxt   = checksum;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          reg_nxt   = FIRST;
          sum_nxt   = '0;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      SETUP: begin
        // val is snapshotted here; later writebacks cannot disturb a pending element
        if (cnt == CNT_LAST) begin
          elem_nxt.data  = val;
          elem_nxt.index = regNo;
          elem_nxt.last  = (regNo == LAST);
          vld_nxt        = 1'b1;
          state_nxt      = HOLD;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (xfer) begin
          sum_nxt = checksum + elem.data;
          vld_nxt = 1'b0;
          if (elem.last) begin
            state_nxt = DONE;
          end else begin
            reg_nxt   = regNo + 5'd1;
            cnt_nxt   = '0;
            state_nxt = SETUP;
          end
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
